// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
//
// Time-multiplexed digit scanner for a common-anode or common-cathode
// multi-digit display. A prescaler divides clk into fixed-length digit slots.
// At the end of each slot the scanner advances to the next digit that is
// enabled in digit_mask, searching circularly from the current index.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   en         : scan enable; when low the scan freezes and the display blanks
//   digit_mask : one bit per digit, 1 = digit is part of the scan set
//   idx        : index of the currently selected digit, for the segment mux
//   anode      : one-hot digit drive at ANODE_ACTIVE_LOW polarity
//   slot_start : one-cycle pulse on the first cycle of a new slot
//   frame_done : one-cycle pulse, with slot_start, when the scan wrapped
// ---------------------------------------------------------------------------
module display_scan #(
   parameter int  NUM_DIGITS       = 4,
   parameter int  DIV              = 65536,
   parameter int  DEADTIME         = 0,
   parameter int  ANODE_ACTIVE_LOW = 1,
   localparam int IDX_W            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [NUM_DIGITS-1:0] digit_mask,
   output logic [IDX_W-1:0]      idx,
   output logic [NUM_DIGITS-1:0] anode,
   output logic                  slot_start,
   output logic                  frame_done
);

   localparam int             PW         = $clog2(DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

   logic [PW-1:0]         r_presc;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_slot_start;
   logic                  r_frame_done;

   logic                  w_adv;
   logic                  w_wrap;
   logic                  w_live;
   logic                  w_found;
   logic [IDX_W-1:0]      w_next_idx;
   logic [NUM_DIGITS-1:0] w_drive;

   // Slot boundary: last prescaler count while the scan is running.
   assign w_adv = en & (r_presc == PRESC_LAST);

   // Circular search for the next enabled digit, starting just after the
   // current one and ending on the current one itself. Comparing against
   // the loop constant (rather than indexing with a computed value) keeps the
   // search inside 0..NUM_DIGITS-1 for any digit count. With an empty mask
   // nothing matches and the index holds.
   always_comb begin
      w_next_idx = r_idx;
      w_found    = 1'b0;
      for (int off = 1; off <= NUM_DIGITS; off++) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!w_found && digit_mask[k] &&
                (k == ((int'(r_idx) + off) % NUM_DIGITS))) begin
               w_next_idx = IDX_W'(k);
               w_found    = 1'b1;
            end
         end
      end
   end

   // A new index not above the old one means the scan passed the top digit,
   // or stayed put (single digit or empty mask).
   assign w_wrap = (w_next_idx <= r_idx);

   // Deadtime blanking at the start of each slot; a zero deadtime needs no
   // comparator at all.
   generate
      if (DEADTIME == 0) begin : g_no_dead
         assign w_live = 1'b1;
      end else begin : g_dead
         assign w_live = (r_presc >= PW'(DEADTIME));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_slot_start <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_slot_start <= w_adv;
         r_frame_done <= w_adv & w_wrap;
         if (en) begin
            if (w_adv) begin
               r_presc <= '0;
               r_idx   <= w_next_idx;
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end
      end
   end

   // Anode decode from registered state. The mask, enable and reset terms
   // are combinational so that clearing the current digit, dropping en or
   // asserting reset blanks the display without waiting for a clock edge.
   always_comb begin
      w_drive = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (int'(r_idx) == k) begin
            w_drive[k] = rst_n & en & w_live & digit_mask[k];
         end
      end
   end

   assign anode      = (ANODE_ACTIVE_LOW != 0) ? ~w_drive : w_drive;
   assign idx        = r_idx;
   // A slot pulse registered just before en drops is suppressed while frozen.
   assign slot_start = r_slot_start & en;
   assign frame_done = r_frame_done & en;

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int DT  = 1;
   localparam int AL  = 1;
   localparam int IW  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [N-1:0]  mask;
   logic [IW-1:0] idx;
   logic [N-1:0]  anode;
   logic          slot_start;
   logic          frame_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: slot counter, selected digit and pending pulses.
   int m_presc;
   int m_idx;
   bit m_ss;
   bit m_fd;

   display_scan #(
      .NUM_DIGITS(N), .DIV(DIV), .DEADTIME(DT), .ANODE_ACTIVE_LOW(AL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask),
      .idx(idx), .anode(anode), .slot_start(slot_start), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Next enabled digit after cur, wrapping; stays on cur if none is enabled.
   function automatic int next_digit(input int cur, input logic [N-1:0] m);
      for (int off = 1; off <= N; off++) begin
         int c;
         c = (cur + off) % N;
         if (((m >> c) & N'(1)) != 0) return c;
      end
      return cur;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_presc <= 0;
         m_idx   <= 0;
         m_ss    <= 1'b0;
         m_fd    <= 1'b0;
      end else if (en) begin
         if (m_presc == DIV - 1) begin
            m_presc <= 0;
            m_idx   <= next_digit(m_idx, mask);
            m_ss    <= 1'b1;
            m_fd    <= (next_digit(m_idx, mask) <= m_idx);
         end else begin
            m_presc <= m_presc + 1;
            m_ss    <= 1'b0;
            m_fd    <= 1'b0;
         end
      end else begin
         m_ss <= 1'b0;
         m_fd <= 1'b0;
      end
   end

   function automatic logic [N-1:0] exp_anode();
      logic [N-1:0] r;
      bit act;
      for (int k = 0; k < N; k++) begin
         act  = rst_n && en && (m_idx == k) && (((mask >> k) & N'(1)) != 0) && (m_presc >= DT);
         r[k] = (AL != 0) ? !act : act;
      end
      return r;
   endfunction

   task automatic compare();
      check("idx", 32'(idx), 32'(m_idx));
      check("anode", 32'(anode), 32'(exp_anode()));
      check("slot_start", 32'(slot_start), 32'(m_ss && en));
      check("frame_done", 32'(frame_done), 32'(m_fd && en));
   endtask

   task automatic cyc(input logic e, input logic [N-1:0] m);
      @(negedge clk);
      en   = e;
      mask = m;
      #1;
      compare();
   endtask

   // Reset asserted between clock edges; outputs must clear with no edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_idx", 32'(idx), 32'd0);
      check("rst_anode", 32'(anode), 32'hF);
      check("rst_slot_start", 32'(slot_start), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compare();
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      mask  = 4'hF;
      #1;
      check("por_idx", 32'(idx), 32'd0);
      check("por_anode", 32'(anode), 32'hF);
      for (int i = 0; i < 3; i++) cyc(1'b1, 4'hF);
      release_reset();

      // Full scan set.
      for (int i = 0; i < 20; i++) cyc(1'b1, 4'hF);
      // Alternate digits.
      for (int i = 0; i < 20; i++) cyc(1'b1, 4'h5);
      // Empty mask: blank, index holds, pulses continue.
      for (int i = 0; i < 12; i++) cyc(1'b1, 4'h0);

      // Freeze at presc=2 for five cycles, then resume.
      while (m_presc != 2) cyc(1'b1, 4'hF);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'hF);
      for (int i = 0; i < 8; i++) cyc(1'b1, 4'hF);

      // Async reset at presc=2 of digit 2.
      while (!(m_presc == 1 && m_idx == 2)) cyc(1'b1, 4'hF);
      async_reset();
      for (int i = 0; i < 2; i++) cyc(1'b1, 4'h2);
      // Single digit 1 from reset.
      release_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 4'h2);

      // Clear the current digit's mask bit mid-slot.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 4'hF);
         cyc(1'b1, 4'hF);
         cyc(1'b1, N'(4'hF & ~(4'h1 << m_idx)));
      end

      // Randomized operation with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            async_reset();
            cyc(($urandom_range(0, 1) == 1), N'($urandom));
            release_reset();
         end else begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0) ? N'($urandom) : mask);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
